// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requesters plus the data memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [1:0]             req_i;
  logic [1:0]             we_i;
  logic [1:0][ADDR_W-1:0] addr_i;
  logic [1:0][DATA_W-1:0] wdata_i;
  logic [1:0][3:0]        size_i;
  logic [1:0]             gnt_o;
  logic [1:0]             done_o;
  logic                   err_o;
  logic [DATA_W-1:0]      rdata_o;
  logic [ADDR_W-1:0]      mem_address;
  logic                   mem_write_enable;
  logic                   mem_read_enable;
  logic [DATA_W-1:0]      mem_write_data;
  logic [3:0]             mem_xfer_size;
  logic [DATA_W-1:0]      mem_read_data;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, size_i, mem_read_data,
    output gnt_o, done_o, err_o, rdata_o,
    output mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, size_i, mem_read_data,
    input  gnt_o, done_o, err_o, rdata_o,
    input  mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_xfer_size
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the data memory; all memory-side outputs are registered.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention, otherwise port 0 has fixed priority.
//
// state | meaning
// IDLE  | no access in flight; grant allowed
// BUSY  | latched command driven to memory for one cycle
// DONE  | completion pulse to owner; a new grant may overlap
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              any_req;
  logic              win;
  logic              grant;
  logic [1:0]        gnt;
  logic [3:0]        sel_size;
  logic              sel_we;
  logic              size_ok;

  logic              owner_q;
  logic              illegal_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        size_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        done_q;
  logic              err_q;

  assign any_req = |bus.req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_q names the port favoured on the next contended grant.
  logic ptr_q;

  always_comb win = (&bus.req_i) ? ptr_q : bus.req_i[1];

  always_ff @(posedge clk) begin
    if (reset)
      ptr_q <= 1'b0;
    else if (grant)
      ptr_q <= ~win;
  end
`else
  always_comb win = ~bus.req_i[0];
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    grant   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (any_req) begin
          grant    = 1'b1;
          gnt[win] = 1'b1;
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_size = bus.size_i[win];
  assign sel_we   = bus.we_i[win];

  always_comb begin
    case (sel_size)
      4'd1, 4'd2, 4'd4, 4'd8: size_ok = 1'b1;
      default:                size_ok = 1'b0;
    endcase
  end

  // Enables are loaded at grant so they are high exactly during BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= 1'b0;
      illegal_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      if (grant) begin
        owner_q   <= win;
        illegal_q <= ~size_ok;
        addr_q    <= bus.addr_i[win];
        wdata_q   <= bus.wdata_i[win];
        size_q    <= sel_size;
        rd_en_q   <= size_ok & ~sel_we;
        wr_en_q   <= size_ok & sel_we;
      end
      if (state_q == BUSY) begin
        done_q <= owner_q ? 2'b10 : 2'b01;
        err_q  <= illegal_q;
        if (rd_en_q)
          rdata_q <= bus.mem_read_data;
      end
    end
  end

  assign bus.gnt_o            = gnt;
  assign bus.done_o           = done_q;
  assign bus.err_o            = err_q;
  assign bus.rdata_o          = rdata_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_enable = wr_en_q;
  assign bus.mem_read_enable  = rd_en_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.mem_xfer_size    = size_q;

endmodule
